// File: rtl/style_pkg.sv
// Shared definitions for the G1 gradient stage: pixel width, saturation ceiling,
// FSM encoding and the absolute-difference helper.
package style_pkg;

   localparam int         PIX_W    = 8;
   localparam logic [7:0] GRAD_MAX = 8'd255;

   typedef enum logic {
      WAIT_SOF = 1'b0,
      STREAM   = 1'b1
   } state_t;

   function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                 input logic [PIX_W-1:0] b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction

endpackage

// File: rtl/gradient_g1_if.sv
// Pixel-in / gradient-out stream bundle for gradient_g1; the source drives the
// i_* side, the gradient stage drives the o_* side.
interface gradient_g1_if;

   logic       i_valid;
   logic       i_sof;
   logic [7:0] iRed;
   logic [7:0] iGreen;
   logic [7:0] iBlue;
   logic       o_valid;
   logic       o_sof;
   logic       o_eol;
   logic [7:0] oRed_G1;
   logic [7:0] oGreen_G1;
   logic [7:0] oBlue_G1;

   modport master (
      output i_valid, i_sof, iRed, iGreen, iBlue,
      input  o_valid, o_sof, o_eol, oRed_G1, oGreen_G1, oBlue_G1
   );

   modport slave (
      input  i_valid, i_sof, iRed, iGreen, iBlue,
      output o_valid, o_sof, o_eol, oRed_G1, oGreen_G1, oBlue_G1
   );

endinterface

// File: rtl/line_buffer_rb.sv
// One-line RGB store with synchronous read; a write to the address being read
// returns the old contents (read-before-write).
module line_buffer_rb #(
   parameter int DEPTH = 640,
   parameter int WIDTH = 24,
   parameter int AW    = 10
) (
   input  logic             clk,
   input  logic             en,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en) begin
         rdata     <= mem[addr];
         mem[addr] <= wdata;
      end
   end

endmodule

// File: rtl/gradient_g1.sv
// Streaming per-channel |dx| + |dy| gradient with 8-bit saturation, two-cycle latency.
// Optional macro GRAD_BORDER_ZERO_EN forces row-0 / col-0 outputs to zero.
module gradient_g1
   import style_pkg::*;
#(
   parameter int IMG_W    = 640,
   parameter int IMG_H    = 480,
   parameter int COL_BITS = 10,
   parameter int ROW_BITS = 9
) (
   input  logic         i_clk,
   input  logic         i_rst,
   gradient_g1_if.slave bus
);

   localparam int                  AW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(IMG_W - 1);
   localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(IMG_H - 1);

   function automatic logic [PIX_W-1:0] sat_grad(input logic [PIX_W:0] sum);
      return sum[PIX_W] ? GRAD_MAX : sum[PIX_W-1:0];
   endfunction

   state_t              state;
   logic [COL_BITS-1:0] col;
   logic [ROW_BITS-1:0] row;

   logic                accept;
   logic [COL_BITS-1:0] col_cur;
   logic [ROW_BITS-1:0] row_cur;
   logic                eol_cur;
   logic                last_cur;
   logic [23:0]         pix_cur;
   logic [23:0]         prev_pix;

   logic                vld_p1, sof_p1, eol_p1, col0_p1, row0_p1;
   logic [23:0]         pix_p1, left_p1, up_p1;
   logic [2:0][7:0]     grad;

   // An accepted sof always lands at (0,0), even mid-frame.
   assign accept   = bus.i_valid && (bus.i_sof || state == STREAM);
   assign col_cur  = bus.i_sof ? '0 : col;
   assign row_cur  = bus.i_sof ? '0 : row;
   assign eol_cur  = (col_cur == COL_LAST);
   assign last_cur = eol_cur && (row_cur == ROW_LAST);
   assign pix_cur  = {bus.iRed, bus.iGreen, bus.iBlue};

   // ---- stage 1: position tracking, line-buffer read, left-pixel capture ----
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state    <= WAIT_SOF;
         col      <= '0;
         row      <= '0;
         vld_p1   <= 1'b0;
         sof_p1   <= 1'b0;
         eol_p1   <= 1'b0;
         prev_pix <= '0;
      end else begin
         vld_p1 <= accept;
         sof_p1 <= accept && bus.i_sof;
         eol_p1 <= accept && eol_cur;
         if (accept) begin
            prev_pix <= pix_cur;
            if (last_cur) begin
               state <= WAIT_SOF;
               col   <= '0;
               row   <= '0;
            end else begin
               state <= STREAM;
               col   <= eol_cur ? '0 : col_cur + 1'b1;
               row   <= eol_cur ? row_cur + 1'b1 : row_cur;
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (accept) begin
         pix_p1  <= pix_cur;
         left_p1 <= prev_pix;
         col0_p1 <= (col_cur == '0);
         row0_p1 <= (row_cur == '0);
      end
   end

   line_buffer_rb #(
      .DEPTH (IMG_W),
      .WIDTH (24),
      .AW    (AW)
   ) u_line_buffer (
      .clk   (i_clk),
      .en    (accept),
      .addr  (col_cur[AW-1:0]),
      .wdata (pix_cur),
      .rdata (up_p1)
   );

   // ---- stage 2: per-channel gradient, borders replicate the current pixel ----
   always_comb begin
      grad = '0;
      for (int c = 0; c < 3; c++) begin
         logic [7:0] cur, left, up;
         cur     = pix_p1[c*8 +: 8];
         left    = col0_p1 ? cur : left_p1[c*8 +: 8];
         up      = row0_p1 ? cur : up_p1[c*8 +: 8];
         grad[c] = sat_grad({1'b0, abs_diff(cur, left)} + {1'b0, abs_diff(cur, up)});
      end
`ifdef GRAD_BORDER_ZERO_EN
      if (col0_p1 || row0_p1) grad = '0;
`endif
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         bus.o_valid   <= 1'b0;
         bus.o_sof     <= 1'b0;
         bus.o_eol     <= 1'b0;
         bus.oRed_G1   <= '0;
         bus.oGreen_G1 <= '0;
         bus.oBlue_G1  <= '0;
      end else begin
         bus.o_valid <= vld_p1;
         bus.o_sof   <= sof_p1;
         bus.o_eol   <= eol_p1;
         if (vld_p1) begin
            bus.oRed_G1   <= grad[2];
            bus.oGreen_G1 <= grad[1];
            bus.oBlue_G1  <= grad[0];
         end
      end
   end

endmodule

// File: tb/tb_gradient_g1.sv
// Directed table-driven bench for gradient_g1 on a 4x3 image, plus a reset-mid-frame sequence.
module tb_gradient_g1;

   localparam int W = 4;
   localparam int H = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   gradient_g1_if bus ();

   gradient_g1 #(
      .IMG_W    (W),
      .IMG_H    (H),
      .COL_BITS (2),
      .ROW_BITS (2)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus.slave)
   );

   typedef struct {
      logic       v, s;
      logic [7:0] r, g, b;
      logic       ev, es, ee;
      logic [7:0] er, eg, eb;
   } vec_t;

   vec_t vecs[$];
   int   ex_idx = 0;
   int   tests  = 0;
   int   fails  = 0;

   function automatic logic [7:0] bz(input logic [7:0] x);
`ifdef GRAD_BORDER_ZERO_EN
      return 8'd0;
`else
      return x;
`endif
   endfunction

   task automatic add_in(input logic v, input logic s, input logic [7:0] r,
                         input logic [7:0] g, input logic [7:0] b);
      vec_t t;
      t.v = v; t.s = s; t.r = r; t.g = g; t.b = b;
      t.ev = 1'b0; t.es = 1'b0; t.ee = 1'b0; t.er = '0; t.eg = '0; t.eb = '0;
      vecs.push_back(t);
   endtask

   task automatic add_ex(input logic ev, input logic es, input logic ee,
                         input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
      vecs[ex_idx].ev = ev; vecs[ex_idx].es = es; vecs[ex_idx].ee = ee;
      vecs[ex_idx].er = er; vecs[ex_idx].eg = eg; vecs[ex_idx].eb = eb;
      ex_idx++;
   endtask

   task automatic idle_in();
      add_in(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
   endtask

   task automatic idle_ex();
      add_ex(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
   endtask

   task automatic drive(input logic v, input logic s, input logic [7:0] r,
                        input logic [7:0] g, input logic [7:0] b);
      bus.i_valid = v; bus.i_sof = s; bus.iRed = r; bus.iGreen = g; bus.iBlue = b;
   endtask

   task automatic chk(input string name, input logic [26:0] act, input logic [26:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [26:0] outs();
      return {bus.o_valid, bus.o_sof, bus.o_eol, bus.oRed_G1, bus.oGreen_G1, bus.oBlue_G1};
   endfunction

   function automatic logic [26:0] ctl_only();
      return {bus.o_valid, bus.o_sof, bus.o_eol, 24'd0};
   endfunction

   initial begin
      logic [7:0] val, eg;

      // flat frame, then one stray non-sof pixel that must be ignored
      for (int p = 0; p < W*H; p++) add_in(1'b1, p == 0, 8'd100, 8'd100, 8'd100);
      add_in(1'b1, 1'b0, 8'd77, 8'd77, 8'd77);
      idle_in(); idle_in();
      idle_ex(); idle_ex();
      for (int p = 0; p < W*H; p++) add_ex(1'b1, p == 0, (p % W) == W-1, 8'd0, 8'd0, 8'd0);
      idle_ex();

      // row-0 red ramp
      for (int c = 0; c < W; c++) add_in(1'b1, c == 0, 8'(10*c), 8'd0, 8'd0);
      idle_in(); idle_in();
      idle_ex(); idle_ex();
      add_ex(1'b1, 1'b1, 1'b0, bz(8'd0), 8'd0, 8'd0);
      for (int c = 1; c < W; c++) add_ex(1'b1, 1'b0, c == W-1, bz(8'd10), 8'd0, 8'd0);

      // single bright pixel at (1,1)
      for (int p = 0; p < W*H; p++) begin
         val = ((p % W) == 1 && (p / W) == 1) ? 8'd255 : 8'd0;
         add_in(1'b1, p == 0, val, val, val);
      end
      idle_in(); idle_in();
      idle_ex(); idle_ex();
      for (int p = 0; p < W*H; p++) begin
         eg = (p == 5 || p == 6 || p == 9) ? 8'd255 : 8'd0;
         add_ex(1'b1, p == 0, (p % W) == W-1, eg, eg, eg);
      end

      // i_valid toggling on a flat image
      for (int k = 0; k < 8; k++) add_in((k % 2) == 0, k == 0, 8'd50, 8'd50, 8'd50);
      idle_in(); idle_in();
      idle_ex(); idle_ex();
      for (int k = 0; k < 8; k++) begin
         if ((k % 2) == 0) add_ex(1'b1, k == 0, k == 6, 8'd0, 8'd0, 8'd0);
         else idle_ex();
      end

      // sof reasserted at col 2
      add_in(1'b1, 1'b1, 8'd10, 8'd0, 8'd0);
      add_in(1'b1, 1'b0, 8'd20, 8'd0, 8'd0);
      add_in(1'b1, 1'b1, 8'd200, 8'd0, 8'd0);
      add_in(1'b1, 1'b0, 8'd210, 8'd0, 8'd0);
      idle_in(); idle_in();
      idle_ex(); idle_ex();
      add_ex(1'b1, 1'b1, 1'b0, bz(8'd0), 8'd0, 8'd0);
      add_ex(1'b1, 1'b0, 1'b0, bz(8'd10), 8'd0, 8'd0);
      add_ex(1'b1, 1'b1, 1'b0, bz(8'd0), 8'd0, 8'd0);
      add_ex(1'b1, 1'b0, 1'b0, bz(8'd10), 8'd0, 8'd0);

      rst = 1'b1;
      drive(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
      repeat (3) @(negedge clk);
      chk("reset_state", outs(), 27'd0);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         if (vecs[i].ev)
            chk($sformatf("vec%0d", i), outs(),
                {vecs[i].ev, vecs[i].es, vecs[i].ee, vecs[i].er, vecs[i].eg, vecs[i].eb});
         else
            chk($sformatf("vec%0d_idle", i), ctl_only(), 27'd0);
         drive(vecs[i].v, vecs[i].s, vecs[i].r, vecs[i].g, vecs[i].b);
      end

      // reset pulsed mid-frame, then non-sof pixels, then a fresh row-0 ramp
      @(negedge clk); drive(1'b1, 1'b1, 8'd10, 8'd0, 8'd0);
      @(negedge clk); drive(1'b1, 1'b0, 8'd20, 8'd0, 8'd0);
      @(negedge clk);
      chk("pre_reset_out", outs(), {3'b110, bz(8'd0), 16'd0});
      drive(1'b1, 1'b0, 8'd30, 8'd0, 8'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("reset_mid_frame", ctl_only(), 27'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         drive(k < 4, 1'b0, 8'(40 + k), 8'd0, 8'd0);
         @(negedge clk);
         chk($sformatf("post_reset_ignored%0d", k), ctl_only(), 27'd0);
      end
      for (int k = 0; k < W + 2; k++) begin
         if (k >= 2)
            chk($sformatf("post_reset_ramp%0d", k - 2), outs(),
                {1'b1, k == 2, k == W + 1, (k == 2) ? bz(8'd0) : bz(8'd10), 16'd0});
         if (k < W) drive(1'b1, k == 0, 8'(10*k), 8'd0, 8'd0);
         else drive(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
         @(negedge clk);
      end
      chk("final_idle", ctl_only(), 27'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
